// File: rtl/instruction_fetch_unit_if.sv
// instruction_fetch_unit_if: memory handshake, redirect/stall control and decode-side outputs of the fetch stage
interface instruction_fetch_unit_if;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        stall_i;
  logic        instr_valid_o;
  logic [31:0] instruction_o;
  logic [31:0] pc_o;
  logic        fault_o;
  modport master (
    output imem_req_o, imem_addr_o, instr_valid_o, instruction_o, pc_o, fault_o,
    input  imem_gnt_i, imem_rvalid_i, imem_rdata_i, redirect_i, redirect_pc_i, stall_i
  );
  modport slave (
    input  imem_req_o, imem_addr_o, instr_valid_o, instruction_o, pc_o, fault_o,
    output imem_gnt_i, imem_rvalid_i, imem_rdata_i, redirect_i, redirect_pc_i, stall_i
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: single-outstanding fetch stage with redirect and stale-response discard.
// Define IFU_MISALIGN_TRAP_EN to trap misaligned redirects into a FAULT state instead of masking bits [1:0].
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input logic clk_i,
  input logic rst_i,
  instruction_fetch_unit_if.master bus
);
  typedef enum logic [2:0] {
    IDLE, REQ, WAIT, HOLD
`ifdef IFU_MISALIGN_TRAP_EN
    , FAULT
`endif
  } state_t;
  state_t state;
  logic [31:0] fetch_pc, instr, pc, tgt;
  logic kill, req, valid;
  assign tgt = bus.redirect_pc_i & 32'hFFFF_FFFC;
  assign bus.imem_req_o = req;
  assign bus.imem_addr_o = fetch_pc;
  assign bus.instr_valid_o = valid;
  assign bus.instruction_o = instr;
  assign bus.pc_o = pc;
`ifdef IFU_MISALIGN_TRAP_EN
  logic fault, trap;
  assign trap = bus.redirect_i && bus.redirect_pc_i[1:0] != 2'b00 && state != IDLE;
  assign bus.fault_o = fault;
`else
  assign bus.fault_o = 1'b0;
`endif
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state <= IDLE;
      fetch_pc <= RESET_PC;
      kill <= 1'b0;
      req <= 1'b0;
      valid <= 1'b0;
      instr <= NOP_WORD;
      pc <= RESET_PC;
`ifdef IFU_MISALIGN_TRAP_EN
      fault <= 1'b0;
`endif
    end else begin
`ifdef IFU_MISALIGN_TRAP_EN
      // a trap abandons any outstanding response: WAIT is left, so late rvalid is ignored
      if (trap) begin
        fault <= 1'b1;
        pc <= bus.redirect_pc_i;
        state <= FAULT;
        req <= 1'b0;
        valid <= 1'b0;
        kill <= 1'b0;
        instr <= NOP_WORD;
      end else
`endif
      case (state)
        IDLE: begin
          state <= REQ;
          req <= 1'b1;
        end
        REQ: begin
          if (bus.redirect_i) fetch_pc <= tgt;
          if (bus.imem_gnt_i) begin
            state <= WAIT;
            kill <= bus.redirect_i;
            req <= 1'b0;
          end
        end
        WAIT: begin
          if (bus.redirect_i) fetch_pc <= tgt;
          if (bus.imem_rvalid_i && !kill && !bus.redirect_i) begin
            instr <= bus.imem_rdata_i;
            pc <= fetch_pc;
            fetch_pc <= fetch_pc + 32'd4;
            state <= HOLD;
            valid <= 1'b1;
          end else if (bus.imem_rvalid_i) begin
            kill <= 1'b0;
            state <= REQ;
            req <= 1'b1;
          end else if (bus.redirect_i) kill <= 1'b1;
        end
        HOLD: begin
          if (bus.redirect_i || !bus.stall_i) begin
            if (bus.redirect_i) fetch_pc <= tgt;
            instr <= NOP_WORD;
            valid <= 1'b0;
            state <= REQ;
            req <= 1'b1;
          end
        end
`ifdef IFU_MISALIGN_TRAP_EN
        FAULT: begin
          if (bus.redirect_i) begin
            fault <= 1'b0;
            fetch_pc <= tgt;
            state <= REQ;
            req <= 1'b1;
          end
        end
`endif
        default: begin
          state <= IDLE;
          req <= 1'b0;
          valid <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: random memory timing, stalls and redirects checked against an in-order PC-stream model
module tb_instruction_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  instruction_fetch_unit_if bus();
  instruction_fetch_unit dut (.clk_i(clk), .rst_i(rst), .bus(bus));
  int errors = 0, checks = 0, consumed = 0;
  int gnt_pct = 100, rv_pct = 100, spur_pct = 0;
  logic pending = 1'b0, hold_prev = 1'b0;
  logic [31:0] pend_addr = 0, exp_pc = 0, prev_pc = 0, prev_instr = 0;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a == 32'h0 ? 32'h0050_0093 : ~a;
  endfunction

  // one clock: drive inputs, check against the model, advance the memory model
  task automatic step(input logic st, input logic rd, input logic [31:0] tg);
    logic took, resp;
    logic [31:0] a;
    bus.stall_i = st;
    bus.redirect_i = rd;
    bus.redirect_pc_i = tg;
    bus.imem_gnt_i = int'($urandom_range(99)) < gnt_pct;
    resp = pending && int'($urandom_range(99)) < rv_pct;
    bus.imem_rvalid_i = resp || (!pending && int'($urandom_range(99)) < spur_pct);
    bus.imem_rdata_i = resp ? mem(pend_addr) : $urandom;
    if (hold_prev) begin
      checks++;
      if (!bus.instr_valid_o || bus.pc_o !== prev_pc || bus.instruction_o !== prev_instr) begin
        errors++;
        $display("FAIL stall_stable valid=%b pc=%h instr=%h required valid=1 pc=%h instr=%h",
                 bus.instr_valid_o, bus.pc_o, bus.instruction_o, prev_pc, prev_instr);
      end
    end
    if (bus.instr_valid_o) begin
      if (!st && !rd) begin
        checks++;
        if (bus.pc_o !== exp_pc || bus.instruction_o !== mem(exp_pc)) begin
          errors++;
          $display("FAIL consume pc=%h instr=%h required pc=%h instr=%h",
                   bus.pc_o, bus.instruction_o, exp_pc, mem(exp_pc));
        end
        exp_pc += 32'd4;
        consumed++;
      end
    end else begin
      checks++;
      if (bus.instruction_o !== NOP) begin
        errors++;
        $display("FAIL idle_nop instr=%h required %h", bus.instruction_o, NOP);
      end
    end
    if (bus.imem_req_o) begin
      checks++;
      if (bus.imem_addr_o !== exp_pc || pending || bus.instr_valid_o) begin
        errors++;
        $display("FAIL request addr=%h outstanding=%b valid=%b required addr=%h outstanding=0 valid=0",
                 bus.imem_addr_o, pending, bus.instr_valid_o, exp_pc);
      end
    end
    hold_prev = bus.instr_valid_o && st && !rd;
    prev_pc = bus.pc_o;
    prev_instr = bus.instruction_o;
    if (rd) exp_pc = tg & 32'hFFFF_FFFC;
    took = bus.imem_req_o && bus.imem_gnt_i;
    a = bus.imem_addr_o;
    @(posedge clk);
    if (resp) pending = 1'b0;
    if (took) begin
      pending = 1'b1;
      pend_addr = a;
    end
    #1;
  endtask

  task automatic hold_reset();
    rst = 1'b1;
    bus.stall_i = 0;
    bus.redirect_i = 0;
    bus.redirect_pc_i = 0;
    bus.imem_gnt_i = 0;
    bus.imem_rvalid_i = 0;
    bus.imem_rdata_i = 0;
    pending = 0;
    hold_prev = 0;
    exp_pc = 0;
    gnt_pct = 100;
    rv_pct = 100;
    spur_pct = 0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    hold_reset();
    rst = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!bus.instr_valid_o && n < 50) begin
      step(1'b1, 1'b0, 32'h0);
      n++;
    end
    checks++;
    if (!bus.instr_valid_o) begin
      errors++;
      $display("FAIL %s_timeout valid=0 required 1", name);
    end
  endtask

  task automatic test_reset();
    hold_reset();
    checks++;
    if (bus.imem_req_o !== 1'b0 || bus.imem_addr_o !== 32'h0 || bus.instr_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl req=%b addr=%h valid=%b required 0/0/0",
               bus.imem_req_o, bus.imem_addr_o, bus.instr_valid_o);
    end
    checks++;
    if (bus.instruction_o !== NOP || bus.pc_o !== 32'h0 || bus.fault_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_data instr=%h pc=%h fault=%b required %h/0/0",
               bus.instruction_o, bus.pc_o, bus.fault_o, NOP);
    end
    rst = 1'b0;
  endtask

  task automatic test_zero_wait();
    do_reset();
    step(0, 0, 0);
    checks++;
    if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h0) begin
      errors++;
      $display("FAIL first_req req=%b addr=%h required 1/0", bus.imem_req_o, bus.imem_addr_o);
    end
    step(0, 0, 0);
    step(0, 0, 0);
    checks++;
    if (bus.instr_valid_o !== 1'b1 || bus.instruction_o !== 32'h0050_0093 || bus.pc_o !== 32'h0) begin
      errors++;
      $display("FAIL first_instr valid=%b instr=%h pc=%h required 1/00500093/0",
               bus.instr_valid_o, bus.instruction_o, bus.pc_o);
    end
    step(0, 0, 0);
    checks++;
    if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h4) begin
      errors++;
      $display("FAIL second_req req=%b addr=%h required 1/4", bus.imem_req_o, bus.imem_addr_o);
    end
  endtask

  task automatic test_stall();
    logic [31:0] p;
    do_reset();
    wait_valid("stall");
    p = bus.pc_o;
    repeat (4) begin
      step(1, 0, 0);
      checks++;
      if (bus.instr_valid_o !== 1'b1 || bus.imem_req_o !== 1'b0 || bus.pc_o !== p) begin
        errors++;
        $display("FAIL stall_hold valid=%b req=%b pc=%h required 1/0/%h",
                 bus.instr_valid_o, bus.imem_req_o, bus.pc_o, p);
      end
    end
    step(0, 0, 0);
    checks++;
    if (bus.instr_valid_o !== 1'b0 || bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== p + 32'd4) begin
      errors++;
      $display("FAIL stall_release valid=%b req=%b addr=%h required 0/1/%h",
               bus.instr_valid_o, bus.imem_req_o, bus.imem_addr_o, p + 32'd4);
    end
  endtask

  task automatic test_redirect_wait();
    do_reset();
    step(0, 0, 0);
    step(0, 0, 0);
    rv_pct = 0;
    step(0, 1, 32'h100);
    checks++;
    if (bus.imem_req_o !== 1'b0 || bus.instr_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL wait_redirect req=%b valid=%b required 0/0", bus.imem_req_o, bus.instr_valid_o);
    end
    rv_pct = 100;
    step(0, 0, 0);
    checks++;
    if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h100 || bus.instr_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL stale_drop req=%b addr=%h valid=%b required 1/100/0",
               bus.imem_req_o, bus.imem_addr_o, bus.instr_valid_o);
    end
    wait_valid("redirect_wait");
    checks++;
    if (bus.pc_o !== 32'h100 || bus.instruction_o !== mem(32'h100)) begin
      errors++;
      $display("FAIL redirect_target pc=%h instr=%h required 100/%h", bus.pc_o, bus.instruction_o, mem(32'h100));
    end
  endtask

  task automatic test_redirect_hold();
    do_reset();
    wait_valid("hold");
    step(0, 1, 32'h240);
    checks++;
    if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h240 || bus.instr_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL hold_redirect req=%b addr=%h valid=%b required 1/240/0",
               bus.imem_req_o, bus.imem_addr_o, bus.instr_valid_o);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    wait_valid("wrap_a");
    step(0, 1, 32'hFFFF_FFFC);
    wait_valid("wrap_b");
    checks++;
    if (bus.pc_o !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL wrap_pc pc=%h required fffffffc", bus.pc_o);
    end
    step(0, 0, 0);
    checks++;
    if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h0) begin
      errors++;
      $display("FAIL wrap_req req=%b addr=%h required 1/0", bus.imem_req_o, bus.imem_addr_o);
    end
  endtask

  task automatic test_misalign();
    do_reset();
    wait_valid("misalign");
    step(0, 1, 32'h102);
`ifdef IFU_MISALIGN_TRAP_EN
    checks++;
    if (bus.fault_o !== 1'b1 || bus.imem_req_o !== 1'b0 || bus.pc_o !== 32'h102 || bus.instr_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL trap_enter fault=%b req=%b pc=%h valid=%b required 1/0/102/0",
               bus.fault_o, bus.imem_req_o, bus.pc_o, bus.instr_valid_o);
    end
    step(0, 1, 32'h103);
    checks++;
    if (bus.fault_o !== 1'b1 || bus.imem_req_o !== 1'b0 || bus.pc_o !== 32'h103) begin
      errors++;
      $display("FAIL trap_stay fault=%b req=%b pc=%h required 1/0/103", bus.fault_o, bus.imem_req_o, bus.pc_o);
    end
    step(0, 1, 32'h200);
    checks++;
    if (bus.fault_o !== 1'b0 || bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h200) begin
      errors++;
      $display("FAIL trap_exit fault=%b req=%b addr=%h required 0/1/200",
               bus.fault_o, bus.imem_req_o, bus.imem_addr_o);
    end
`else
    checks++;
    if (bus.fault_o !== 1'b0 || bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h100) begin
      errors++;
      $display("FAIL misalign_mask fault=%b req=%b addr=%h required 0/1/100",
               bus.fault_o, bus.imem_req_o, bus.imem_addr_o);
    end
`endif
  endtask

  task automatic test_async_reset();
    do_reset();
    step(0, 0, 0);
    step(0, 0, 0);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.imem_req_o !== 1'b0 || bus.instr_valid_o !== 1'b0 || bus.imem_addr_o !== 32'h0 || bus.instruction_o !== NOP) begin
      errors++;
      $display("FAIL async_reset req=%b valid=%b addr=%h instr=%h required 0/0/0/%h",
               bus.imem_req_o, bus.instr_valid_o, bus.imem_addr_o, bus.instruction_o, NOP);
    end
    do_reset();
  endtask

  task automatic test_random();
    logic [31:0] tg;
    do_reset();
    gnt_pct = 60;
    rv_pct = 50;
    spur_pct = 20;
    step(0, 0, 0);
    consumed = 0;
    for (int i = 0; i < 3000; i++) begin
      tg = $urandom_range(3) == 0 ? 32'hFFFF_FFF0 + ($urandom_range(3) << 2) : $urandom & 32'h0000_FFFC;
      step(int'($urandom_range(99)) < 30, int'($urandom_range(99)) < 8, tg);
    end
    checks++;
    if (consumed < 100) begin
      errors++;
      $display("FAIL random_progress consumed=%0d required at least 100", consumed);
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_stall();
    test_redirect_wait();
    test_redirect_hold();
    test_wrap();
    test_misalign();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
